// File: rtl/cordic_pkg.sv
// Shared constants and FSM state encoding for the CORDIC batch issuer and
// the surrounding accelerator glue.
package cordic_pkg;

  localparam int CORDIC_DATA_W  = 32;
  localparam int CORDIC_COUNT_W = 16;
  // Matches the enabled-cycle latency of cordic_pipeline.
  localparam int CORDIC_LATENCY = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/cordic_token_delay.sv
// One-bit token delay line that mirrors the occupancy of the CORDIC pipeline.
// A token entering here emerges DEPTH enabled cycles later, exactly when the
// matching result is present on ci_result.
module cordic_token_delay
  import cordic_pkg::*;
#(
  parameter int DEPTH = CORDIC_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic token_in,
  output logic token_out
);

  logic [DEPTH-1:0] tok;

  // Shift the occupancy tokens only on enabled cycles so they stay aligned with the stalled pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tok <= '0;
    end else if (enable) begin
      tok <= (tok << 1) | DEPTH'(token_in);
    end
  end

  assign token_out = tok[DEPTH-1];

endmodule

// File: rtl/cordic_batch_issuer.sv
// Initiator for the cordic_pipeline custom instruction. Accepts a batch of
// operands on a valid/ready stream, issues at most one per cycle, and returns
// results in order on a valid/ready stream. Output backpressure freezes the
// whole pipeline through ci_clk_en so nothing in flight is ever lost.
module cordic_batch_issuer
  import cordic_pkg::*;
#(
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int DATA_W  = CORDIC_DATA_W,
  parameter int COUNT_W = CORDIC_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               ci_aclr,
  output logic               ci_clk_en,
  output logic [DATA_W-1:0]  ci_dataa,
  input  logic [DATA_W-1:0]  ci_result
);

  state_t             state;
  logic [COUNT_W-1:0] batch_len;
  logic [COUNT_W-1:0] issued;
  logic [COUNT_W-1:0] delivered;
  logic               in_fire;
  logic               out_fire;
  logic               tok_out;

  // The pipeline clears whenever this block is in reset, so an aborted batch leaves nothing behind.
  assign ci_aclr   = ~reset;
  // A held, unaccepted result stalls everything upstream of the output register.
  assign ci_clk_en = ~out_valid | out_ready;
  assign in_ready  = (state == ST_ISSUE) & ci_clk_en & (issued < batch_len);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  cordic_token_delay #(
    .DEPTH(LATENCY)
  ) u_token_delay (
    .clock    (clock),
    .reset    (reset),
    .enable   (ci_clk_en),
    .token_in (in_fire),
    .token_out(tok_out)
  );

  // Batch sequencing: latch the length on start, count issues and deliveries, pulse done once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      batch_len <= '0;
      issued    <= '0;
      delivered <= '0;
    end else if (ci_clk_en) begin
      if (in_fire) begin
        issued <= issued + 1'b1;
      end
      if (out_fire) begin
        delivered <= delivered + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            batch_len <= count;
            state     <= (count == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issued == batch_len) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_fire && (delivered + 1'b1 == batch_len)) begin
            state <= ST_DONE;
          end
        end
        default: begin
          issued    <= '0;
          delivered <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand register feeding the pipeline and the result register that the sink drains.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ci_dataa  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ci_clk_en) begin
      if (in_fire) begin
        ci_dataa <= in_data;
      end
      if (tok_out) begin
        out_data  <= ci_result;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
